// File: rtl/qc_row_xor_accumulator_if.sv
// Row accumulator stream bundle.
// Purpose: groups the input block stream (valid/ready/vector) and the row-result
// stream (valid/ready/vector plus zero flag and row bookkeeping).
// Modports:
//   slave  - the accumulator: consumes in_*, produces out_*, sees out_ready.
//   master - the environment: produces in_*, consumes out_*, drives out_ready.
interface qc_row_xor_accumulator_if #(
  parameter int unsigned MAX_BLOCK_SIZE = 64,
  parameter int unsigned MAX_ROWS       = 12,
  parameter int unsigned ROW_W          = $clog2(MAX_ROWS + 1)
);
  logic                      in_valid;
  logic                      in_ready;
  logic [MAX_BLOCK_SIZE-1:0] in_vector;
  logic                      out_valid;
  logic                      out_ready;
  logic [MAX_BLOCK_SIZE-1:0] out_vector;
  logic                      out_zero;
  logic [ROW_W-1:0]          out_row_idx;
  logic                      out_last;

  modport slave (
    input  in_valid, in_vector, out_ready,
    output in_ready, out_valid, out_vector, out_zero, out_row_idx, out_last
  );

  modport master (
    output in_valid, in_vector, out_ready,
    input  in_ready, out_valid, out_vector, out_zero, out_row_idx, out_last
  );
endinterface

// File: rtl/qc_row_xor_accumulator.sv
// QC-LDPC row XOR accumulator.
// Purpose: XOR-accumulates one rotated circulant block per non-trivial column of
// a base-matrix row and presents the row result (parity or syndrome block) with
// a zero flag, the row index and a last-row-of-frame flag.
// Ports:
//   clk      - single rising-edge clock
//   rst      - synchronous active-high reset
//   num_cols - blocks in the current row, sampled on the row's first beat
//   num_rows - rows in the frame, sampled on the first beat of row 0
//   bus      - stream bundle (slave modport): in_* block input, out_* row result
module qc_row_xor_accumulator #(
  parameter int unsigned MAX_BLOCK_SIZE = 64,
  parameter int unsigned MAX_COLS       = 24,
  parameter int unsigned MAX_ROWS       = 12,
  parameter int unsigned COL_W          = $clog2(MAX_COLS + 1),
  parameter int unsigned ROW_W          = $clog2(MAX_ROWS + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [COL_W-1:0]            num_cols,
  input  logic [ROW_W-1:0]            num_rows,
  qc_row_xor_accumulator_if.slave     bus
);

  typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

  state_e                    state_q, state_d;
  logic [MAX_BLOCK_SIZE-1:0] acc_q, acc_d;
  logic [COL_W-1:0]          col_cnt_q, col_cnt_d;
  logic [COL_W-1:0]          cols_l_q, cols_l_d;
  logic [ROW_W-1:0]          row_cnt_q, row_cnt_d;
  logic [ROW_W-1:0]          rows_l_q, rows_l_d;

  logic [COL_W-1:0]          cols_eff;
  logic [ROW_W-1:0]          rows_eff;
  logic                      is_last;

  logic                      in_ready;
  logic                      out_valid;
  logic [MAX_BLOCK_SIZE-1:0] out_vector;
  logic                      out_zero;
  logic                      out_last;

  // A zero count is treated as one so a row always consumes at least one block.
  assign cols_eff = (num_cols == '0) ? COL_W'(1) : num_cols;
  assign rows_eff = (num_rows == '0) ? ROW_W'(1) : num_rows;
  assign is_last  = (row_cnt_q == rows_l_q - ROW_W'(1));

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    col_cnt_d  = col_cnt_q;
    cols_l_d   = cols_l_q;
    row_cnt_d  = row_cnt_q;
    rows_l_d   = rows_l_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_vector = '0;
    out_zero   = 1'b0;
    out_last   = 1'b0;

    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          acc_d     = bus.in_vector;
          cols_l_d  = cols_eff;
          col_cnt_d = COL_W'(1);
          if (row_cnt_q == '0) begin
            rows_l_d = rows_eff;
          end
          state_d = (cols_eff == COL_W'(1)) ? StHold : StAccum;
        end
      end
      StAccum: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          acc_d     = acc_q ^ bus.in_vector;
          col_cnt_d = col_cnt_q + COL_W'(1);
          if (col_cnt_q == cols_l_q - COL_W'(1)) begin
            state_d = StHold;
          end
        end
      end
      StHold: begin
        out_valid  = 1'b1;
        out_vector = acc_q;
        out_zero   = (acc_q == '0);
        out_last   = is_last;
        if (bus.out_ready) begin
          state_d   = StIdle;
          row_cnt_d = is_last ? '0 : row_cnt_q + ROW_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      col_cnt_q <= '0;
      cols_l_q  <= COL_W'(1);
      row_cnt_q <= '0;
      rows_l_q  <= ROW_W'(1);
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      col_cnt_q <= col_cnt_d;
      cols_l_q  <= cols_l_d;
      row_cnt_q <= row_cnt_d;
      rows_l_q  <= rows_l_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.out_vector  = out_vector;
  assign bus.out_zero    = out_zero;
  assign bus.out_row_idx = row_cnt_q;
  assign bus.out_last    = out_last;

endmodule

// File: tb/tb_qc_row_xor_accumulator.sv
module tb_qc_row_xor_accumulator;
  localparam int unsigned MAX_BLOCK_SIZE = 64;
  localparam int unsigned MAX_COLS       = 24;
  localparam int unsigned MAX_ROWS       = 12;
  localparam int unsigned COL_W          = $clog2(MAX_COLS + 1);
  localparam int unsigned ROW_W          = $clog2(MAX_ROWS + 1);

  logic             clk;
  logic             rst;
  logic [COL_W-1:0] num_cols;
  logic [ROW_W-1:0] num_rows;

  qc_row_xor_accumulator_if #(
    .MAX_BLOCK_SIZE(MAX_BLOCK_SIZE),
    .MAX_ROWS      (MAX_ROWS),
    .ROW_W         (ROW_W)
  ) bus ();

  qc_row_xor_accumulator #(
    .MAX_BLOCK_SIZE(MAX_BLOCK_SIZE),
    .MAX_COLS      (MAX_COLS),
    .MAX_ROWS      (MAX_ROWS),
    .COL_W         (COL_W),
    .ROW_W         (ROW_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .num_cols(num_cols),
    .num_rows(num_rows),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Out-of-contract sizes must never be presented on an accepted beat.
  always @(posedge clk) begin
    if (!rst && bus.in_valid && bus.in_ready) begin
      assert (num_cols <= COL_W'(MAX_COLS))
        else $error("num_cols %0d exceeds MAX_COLS", num_cols);
      assert (num_rows <= ROW_W'(MAX_ROWS))
        else $error("num_rows %0d exceeds MAX_ROWS", num_rows);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;
  int seen_last;

  logic [63:0] row_v [0:23];
  int          row_g [0:23];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drives one row from row_v/row_g and checks its result against the expectation.
  task automatic run_row(input int ncols, input int nrows, input int stall,
                         input logic [63:0] exp_vec, input int exp_idx,
                         input bit exp_last, input string tag);
    int nb;
    int t;
    nb = (ncols == 0) ? 1 : ncols;
    bus.out_ready = (stall == 0);
    num_rows = ROW_W'(nrows);
    for (int b = 0; b < nb; b++) begin
      bus.in_valid = 1'b0;
      repeat (row_g[b]) @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.in_vector = row_v[b];
      // After the first beat the size inputs are noise the DUT must ignore.
      if (b == 0) num_cols = COL_W'(ncols);
      else begin
        num_cols = COL_W'($urandom_range(0, MAX_COLS));
        num_rows = ROW_W'($urandom_range(1, MAX_ROWS));
      end
      t = 0;
      while (!bus.in_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (!bus.in_ready) chk({tag, " in_ready timeout"}, 64'(bus.in_ready), 64'd1);
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.in_vector = {$urandom, $urandom};
    chk({tag, " out_valid"}, 64'(bus.out_valid), 64'd1);
    chk({tag, " in_ready hold"}, 64'(bus.in_ready), 64'd0);
    chk({tag, " vector"}, bus.out_vector, exp_vec);
    chk({tag, " zero"}, 64'(bus.out_zero), 64'(exp_vec == 64'd0));
    chk({tag, " row_idx"}, 64'(bus.out_row_idx), 64'(exp_idx));
    chk({tag, " last"}, 64'(bus.out_last), 64'(exp_last));
    if (bus.out_valid && bus.out_last) seen_last++;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk({tag, " stall valid"}, 64'(bus.out_valid), 64'd1);
      chk({tag, " stall vector"}, bus.out_vector, exp_vec);
      chk({tag, " stall idx"}, 64'(bus.out_row_idx), 64'(exp_idx));
      chk({tag, " stall last"}, 64'(bus.out_last), 64'(exp_last));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk({tag, " out_valid drop"}, 64'(bus.out_valid), 64'd0);
    chk({tag, " in_ready back"}, 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b0;
  endtask

  typedef struct {
    int          ncols;
    int          nrows;
    logic [63:0] v [4];
    int          g [4];
    int          stall;
    logic [63:0] exp_vec;
    int          exp_idx;
    bit          exp_last;
  } vec_t;

  vec_t tv [7];

  task automatic set_tv(input int i, input int nc, input int nr,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] c, input logic [63:0] d,
                        input int g1, input int g2, input int g3, input int stall,
                        input logic [63:0] e, input int idx, input bit last);
    tv[i].ncols = nc;  tv[i].nrows = nr;
    tv[i].v[0] = a;    tv[i].v[1] = b;    tv[i].v[2] = c;    tv[i].v[3] = d;
    tv[i].g[0] = 0;    tv[i].g[1] = g1;   tv[i].g[2] = g2;   tv[i].g[3] = g3;
    tv[i].stall = stall;
    tv[i].exp_vec = e; tv[i].exp_idx = idx; tv[i].exp_last = last;
  endtask

  initial begin
    int          rows_done;
    int          nrows;
    int          ncols;
    int          nb;
    int          stall;
    logic [63:0] exp_v;

    rst           = 1'b1;
    num_cols      = '0;
    num_rows      = '0;
    bus.in_valid  = 1'b0;
    bus.in_vector = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("reset in_ready", 64'(bus.in_ready), 64'd1);
    chk("reset out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset out_vector", bus.out_vector, 64'd0);
    chk("reset out_zero", 64'(bus.out_zero), 64'd0);
    chk("reset out_row_idx", 64'(bus.out_row_idx), 64'd0);
    chk("reset out_last", 64'(bus.out_last), 64'd0);

    //     i nc nr  beats                          gaps     stl exp    idx last
    set_tv(0, 3, 1, 64'hF0, 64'h0F, 64'hFF, 64'h0, 0, 0, 0, 0, 64'h0,  0, 1);
    set_tv(1, 1, 1, 64'hA5, 64'h0,  64'h0,  64'h0, 0, 0, 0, 0, 64'hA5, 0, 1);
    set_tv(2, 0, 1, 64'hA5, 64'h0,  64'h0,  64'h0, 0, 0, 0, 0, 64'hA5, 0, 1);
    set_tv(3, 2, 2, 64'h1,  64'h2,  64'h0,  64'h0, 0, 0, 0, 5, 64'h3,  0, 0);
    set_tv(4, 2, 7, 64'h4,  64'h0,  64'h0,  64'h0, 0, 0, 0, 5, 64'h4,  1, 1);
    set_tv(5, 1, 1, 64'h55, 64'h0,  64'h0,  64'h0, 0, 0, 0, 0, 64'h55, 0, 1);
    set_tv(6, 4, 1, 64'h8,  64'h4,  64'h2,  64'h1, 0, 3, 7, 0, 64'hF,  0, 1);

    for (int i = 0; i < 7; i++) begin
      for (int b = 0; b < 4; b++) begin
        row_v[b] = tv[i].v[b];
        row_g[b] = tv[i].g[b];
      end
      run_row(tv[i].ncols, tv[i].nrows, tv[i].stall, tv[i].exp_vec,
              tv[i].exp_idx, tv[i].exp_last, $sformatf("vec%0d", i));
    end

    // Complete row 0 of a 3-row frame so row_cnt is non-zero before the abort.
    row_v[0] = 64'h9; row_g[0] = 0;
    run_row(1, 3, 0, 64'h9, 0, 1'b0, "pre_abort");
    num_cols      = COL_W'(3);
    bus.in_valid  = 1'b1;
    bus.in_vector = 64'h11;
    @(negedge clk);
    bus.in_vector = 64'h22;
    rst           = 1'b1;
    @(negedge clk);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    chk("abort out_valid", 64'(bus.out_valid), 64'd0);
    chk("abort in_ready", 64'(bus.in_ready), 64'd1);
    row_v[0] = 64'h3; row_v[1] = 64'h5; row_g[0] = 0; row_g[1] = 0;
    run_row(2, 1, 0, 64'h6, 0, 1'b1, "after_abort");

    // Reset while a result is pending in HOLD.
    bus.out_ready = 1'b0;
    num_cols      = COL_W'(1);
    num_rows      = ROW_W'(2);
    bus.in_valid  = 1'b1;
    bus.in_vector = 64'h77;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("hold_rst pending", 64'(bus.out_valid), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("hold_rst out_valid", 64'(bus.out_valid), 64'd0);
    chk("hold_rst row_idx", 64'(bus.out_row_idx), 64'd0);

    // Random frames against a plain XOR-per-row model.
    rows_done = 0;
    while (rows_done < 1000) begin
      nrows     = $urandom_range(1, MAX_ROWS);
      seen_last = 0;
      for (int r = 0; r < nrows; r++) begin
        ncols = $urandom_range(0, MAX_COLS);
        nb    = (ncols == 0) ? 1 : ncols;
        exp_v = '0;
        for (int b = 0; b < nb; b++) begin
          row_v[b] = ($urandom_range(0, 7) == 0) ? 64'd0 : {$urandom, $urandom};
          row_g[b] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
        end
        if (nb > 1 && $urandom_range(0, 3) == 0) begin
          row_v[nb-1] = '0;
          for (int b = 0; b < nb - 1; b++) row_v[nb-1] = row_v[nb-1] ^ row_v[b];
        end
        for (int b = 0; b < nb; b++) exp_v = exp_v ^ row_v[b];
        stall = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
        run_row(ncols, nrows, stall, exp_v, r, (r == nrows - 1),
                $sformatf("rand row %0d", rows_done));
        rows_done++;
      end
      chk($sformatf("rand last per frame at row %0d", rows_done), 64'(seen_last), 64'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
